neuron_input_loader: RTL and testbench
======================================

// Module: neuron_input_loader
// PURPOSE
// Upstream stage of neuron_input128. Accepts a beat-serial valid/ready stream of signed
// 32-bit activations and assembles 128-beat frames in a shadow bank. A completed frame is
// committed in one cycle to a parallel vector that drives input_in of neuron_input128.
// res_valid marks the cycle in which output_out carries that frame's result.
// PARAMETERS
// N_INPUTS     128  beats per frame = neuron fan-in
// DATA_W       32   beat / vector element width, two's complement (integer)
// NEURON_LAT   5    clk cycles from vec_strobe to the matching valid output_out
// MIN_HOLD     1    min cycles between two commits, >=1
// PORTS
// clk        in   1                  clock, all state on posedge
// rst_n      in   1                  async active-low reset
// flush      in   1                  sync: drop partial frame and pending res_valid tags
// s_valid    in   1                  beat valid
// s_ready    out  1                  beat accepted when s_valid && s_ready
// s_data     in   DATA_W             beat payload
// s_last     in   1                  marks beat N_INPUTS-1 of a frame
// vec_data   out  N_INPUTS x DATA_W  committed vector -> neuron input_in
// vec_strobe out  1                  1-cycle pulse, first cycle of a new vec_data
// res_valid  out  1                  pulse NEURON_LAT cycles after vec_strobe
// frame_err  out  1                  1-cycle pulse on framing violation
// BEHAVIOUR
// - Reset (async, rst_n=0): state=FILL, wr_idx=0, vec_data all 0, s_ready=0 while in reset,
//   vec_strobe/res_valid/frame_err=0, hold_cnt=0, delay line cleared. s_ready=1 from the first cycle after release.
// - FSM FILL/FULL/DROP. All outputs registered. s_ready = (state!=FULL).
// - FILL: each accepted beat writes shadow[wr_idx], then wr_idx++.
//   * wr_idx==N-1 && s_last: -> FULL, wr_idx=0.
//   * wr_idx==N-1 && !s_last: frame_err, -> DROP, discard the frame.
//   * wr_idx<N-1 && s_last: frame_err, wr_idx=0, stay FILL. The partial frame is discarded.
// - DROP: accept and discard beats. The beat with s_last -> FILL, wr_idx=0. No second frame_err.
// - FULL: commit when hold_cnt==0. In that cycle:
//   * vec_data<=shadow on the next edge; vec_strobe=1 in the cycle vec_data first shows the new frame.
//   * hold_cnt<=MIN_HOLD-1; state -> FILL.
//   * Earliest commit is the cycle after the last beat, so a single frame loads in N_INPUTS+1 cycles.
// - hold_cnt decrements to 0 and saturates there. No commit while it is nonzero.
// - vec_data stays stable between commits. It is never partially updated.
// - res_valid: vec_strobe delayed exactly NEURON_LAT cycles.
//   * Multiple tags may be in flight; each pulse is independent.
// - flush: -> FILL, wr_idx=0, delay line and hold_cnt cleared.
//   * vec_data is kept and no vec_strobe is issued.
//   * flush wins over a beat or commit in the same cycle.
// - Reset mid-frame: all state lost. The frame in flight is neither committed nor flagged.
// - s_data is not touched arithmetically. It is stored bit-exact; no saturation or widening.
// STRUCTURE
// - neuron_pkg: N_INPUTS, DATA_W defaults, typedef enum logic[1:0] {FILL,FULL,DROP} ldr_state_t,
//   typedef logic signed [DATA_W-1:0] act_t.
// - Sub-module valid_delay_line #(DEPTH): DEPTH-stage 1-bit shift register with async reset and sync clear.
//   It produces res_valid.
// - The shadow bank is a flop array, because the commit copies all N_INPUTS words in parallel; it is not RAM.
// TESTING
// - Back-to-back frame, s_data=k+1 for beat k, s_last on beat 127 -> vec_data[k]==k+1.
//   vec_strobe fires the cycle after the last beat; res_valid fires 5 cycles after vec_strobe.
// - s_last on beat 63 -> frame_err 1 cycle, no vec_strobe, vec_data unchanged.
//   The next clean frame commits normally.
// - No s_last at beat 127 -> frame_err, DROP. Send 10 more beats, last with s_last -> no commit;
//   the following clean frame commits.
// - MIN_HOLD=200, two frames back-to-back -> s_ready=0 after the 2nd frame's last beat
//   until 200 cycles after the 1st commit. The 2nd vec_strobe fires exactly then.
// - flush at beat 50 with a res_valid tag in flight -> no res_valid, wr_idx=0, vec_data kept.
// - rst_n low mid-frame, asynchronously -> outputs zero immediately (vec_data=0, pulses low).
//   After release a full frame commits correctly.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and sizes for the neuron input path: frame geometry, activation type
// and the loader FSM states.
package neuron_pkg;

    localparam int N_INPUTS = 128;
    localparam int DATA_W   = 32;
    localparam int IDX_W    = $clog2(N_INPUTS);

    typedef enum logic [1:0] {FILL, FULL, DROP} ldr_state_t;

    typedef logic signed [DATA_W-1:0]         act_t;
    typedef logic [N_INPUTS-1:0][DATA_W-1:0] vec_t;

endpackage

// File: rtl/valid_delay_line.sv
// DEPTH-stage 1-bit delay line; a pulse on din appears on dout DEPTH cycles later.
// clear drops every pulse still in flight.
module valid_delay_line #(
    parameter int DEPTH = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] taps;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps <= '0;
        end else if (clear) begin
            taps <= '0;
        end else begin
            taps <= DEPTH'({taps, din});
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/neuron_input_loader.sv
// Beat-serial activation loader: assembles N_INPUTS-beat frames in a shadow bank and
// commits each complete frame in one cycle to the parallel neuron input vector.
module neuron_input_loader
    import neuron_pkg::*;
#(
    parameter int NEURON_LAT = 5,
    parameter int MIN_HOLD   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic s_valid,
    output logic s_ready,
    input  act_t s_data,
    input  logic s_last,
    output vec_t vec_data,
    output logic vec_strobe,
    output logic res_valid,
    output logic frame_err
);

    localparam int HOLD_W = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;

    ldr_state_t        state, state_nxt;
    logic [IDX_W-1:0]  wr_idx, wr_idx_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              beat_fire, commit, err_nxt, shadow_we;
    act_t              shadow [N_INPUTS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // flush overrides everything; hold_cnt only gates the FULL -> FILL commit
    always_comb begin
        state_nxt  = state;
        wr_idx_nxt = wr_idx;
        hold_nxt   = (hold_cnt != '0) ? hold_cnt - 1'b1 : hold_cnt;
        commit     = 1'b0;
        err_nxt    = 1'b0;
        shadow_we  = 1'b0;
        beat_fire  = s_valid && s_ready;
        if (flush) begin
            state_nxt  = FILL;
            wr_idx_nxt = '0;
            hold_nxt   = '0;
        end else begin
            case (state)
                FILL: begin
                    if (beat_fire) begin
                        shadow_we = 1'b1;
                        if (wr_idx == IDX_W'(N_INPUTS - 1)) begin
                            wr_idx_nxt = '0;
                            if (s_last) begin
                                state_nxt = FULL;
                            end else begin
                                err_nxt   = 1'b1;
                                state_nxt = DROP;
                            end
                        end else if (s_last) begin
                            err_nxt    = 1'b1;
                            wr_idx_nxt = '0;
                        end else begin
                            wr_idx_nxt = wr_idx + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (hold_cnt == '0) begin
                        commit    = 1'b1;
                        hold_nxt  = HOLD_W'(MIN_HOLD - 1);
                        state_nxt = FILL;
                    end
                end
                DROP: begin
                    if (beat_fire && s_last) begin
                        state_nxt  = FILL;
                        wr_idx_nxt = '0;
                    end
                end
                default: begin
                    state_nxt  = FILL;
                    wr_idx_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx     <= '0;
            hold_cnt   <= '0;
            s_ready    <= 1'b0;
            vec_strobe <= 1'b0;
            frame_err  <= 1'b0;
            vec_data   <= '0;
        end else begin
            wr_idx     <= wr_idx_nxt;
            hold_cnt   <= hold_nxt;
            s_ready    <= (state_nxt != FULL);
            vec_strobe <= commit;
            frame_err  <= err_nxt;
            if (commit) begin
                for (int i = 0; i < N_INPUTS; i++) begin
                    vec_data[i] <= shadow[i];
                end
            end
        end
    end

    // Flop bank rather than RAM: the commit reads every word in the same cycle
    always_ff @(posedge clk) begin
        if (shadow_we) begin
            shadow[wr_idx] <= s_data;
        end
    end

    valid_delay_line #(
        .DEPTH(NEURON_LAT)
    ) u_res_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .din   (vec_strobe),
        .dout  (res_valid)
    );

endmodule

// File: tb/tb_neuron_input_loader.sv
// Self-checking bench for neuron_input_loader: frame-level reference model compared every
// cycle, directed framing/flush/reset cases, and a long-hold instance for commit spacing.
module tb_neuron_input_loader;
    import neuron_pkg::*;

    localparam int LAT    = 5;
    localparam int HOLD_A = 1;
    localparam int HOLD_B = 200;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic flush   = 1'b0;
    logic s_valid = 1'b0;
    logic s_last  = 1'b0;
    act_t s_data  = '0;

    logic s_ready_a, vec_strobe_a, res_valid_a, frame_err_a;
    logic s_ready_b, vec_strobe_b, res_valid_b, frame_err_b;
    vec_t vec_data_a, vec_data_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit use_b  = 1'b0;

    // Reference model state: frame progress counted in beats, commits in edge numbers
    vec_t              m_vec = '0;
    logic [DATA_W-1:0] m_frame [N_INPUTS];
    bit m_ready = 0, m_strobe = 0, m_res = 0, m_err = 0;
    bit m_full = 0, m_drop = 0, m_hold_armed = 0, m_fire = 0;
    int m_cnt = 0, m_edge = 0, m_last_commit = 0;
    int m_tags[$];

    neuron_input_loader #(.NEURON_LAT(LAT), .MIN_HOLD(HOLD_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .s_valid(s_valid), .s_ready(s_ready_a),
        .s_data(s_data), .s_last(s_last), .vec_data(vec_data_a), .vec_strobe(vec_strobe_a),
        .res_valid(res_valid_a), .frame_err(frame_err_a)
    );

    neuron_input_loader #(.NEURON_LAT(LAT), .MIN_HOLD(HOLD_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .s_valid(s_valid), .s_ready(s_ready_b),
        .s_data(s_data), .s_last(s_last), .vec_data(vec_data_b), .vec_strobe(vec_strobe_b),
        .res_valid(res_valid_b), .frame_err(frame_err_b)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Model: one step per clock edge using the inputs as they stood before the edge
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_ready = 0; m_strobe = 0; m_res = 0; m_err = 0; m_vec = '0;
            m_cnt = 0; m_drop = 0; m_full = 0; m_hold_armed = 0;
            m_tags.delete();
        end else begin
            m_edge++;
            m_fire   = s_valid && m_ready;
            m_strobe = 0;
            m_err    = 0;
            m_res    = 0;
            if (m_tags.size() > 0 && m_tags[0] == m_edge) begin
                m_res = 1;
                void'(m_tags.pop_front());
            end
            if (flush) begin
                m_cnt = 0; m_drop = 0; m_full = 0; m_hold_armed = 0; m_res = 0;
                m_tags.delete();
            end else if (m_full) begin
                if (!m_hold_armed || (m_edge - m_last_commit) >= HOLD_A) begin
                    for (int i = 0; i < N_INPUTS; i++) m_vec[i] = m_frame[i];
                    m_strobe      = 1;
                    m_full        = 0;
                    m_hold_armed  = 1;
                    m_last_commit = m_edge;
                    m_tags.push_back(m_edge + LAT);
                end
            end else if (m_drop) begin
                if (m_fire && s_last) m_drop = 0;
            end else if (m_fire) begin
                m_frame[m_cnt] = s_data;
                m_cnt++;
                if (m_cnt == N_INPUTS) begin
                    m_cnt = 0;
                    if (s_last) m_full = 1;
                    else begin
                        m_err  = 1;
                        m_drop = 1;
                    end
                end else if (s_last) begin
                    m_err = 1;
                    m_cnt = 0;
                end
            end
            m_ready = !m_full;
        end
    end

    initial forever begin
        @(negedge clk);
        checkOutput("s_ready", s_ready_a, m_ready);
        checkOutput("vec_strobe", vec_strobe_a, m_strobe);
        checkOutput("res_valid", res_valid_a, m_res);
        checkOutput("frame_err", frame_err_a, m_err);
        checks++;
        if (vec_data_a !== m_vec) begin
            int idx;
            idx = 0;
            for (int i = N_INPUTS - 1; i >= 0; i--) if (vec_data_a[i] !== m_vec[i]) idx = i;
            errors++;
            $display("[TB] FAIL vec_data[%0d]: got 0x%0h, expected 0x%0h (cycle %0d)",
                     idx, vec_data_a[idx], m_vec[idx], cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input act_t data, input bit last, input int gap_pct);
        bit acc;
        for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++) tick(1);
        s_valid = 1'b1;
        s_data  = data;
        s_last  = last;
        acc     = 1'b0;
        for (int n = 0; n < 1000 && !acc; n++) begin
            acc = use_b ? s_ready_b : s_ready_a;
            tick(1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_accept_timeout: got no s_ready, expected s_ready within 1000 cycles");
        end
    endtask

    task automatic sendFrame(input int n_beats, input int last_at, input bit rand_data,
                             input int base, input int gap_pct);
        act_t d;
        for (int k = 0; k < n_beats; k++) begin
            d = rand_data ? act_t'($urandom()) : act_t'(base + k + 1);
            applyStimulus(d, k == last_at, gap_pct);
        end
    endtask

    task automatic flushCycle();
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r, len, c1;
        tick(3);
        checkOutput("reset_s_ready", s_ready_a, 0);
        checkOutput("reset_vec_data0", vec_data_a[0], 0);
        rst_n = 1'b1;
        tick(1);
        checkOutput("ready_after_release", s_ready_a, 1);

        $display("[TB] clean frame, data k+1");
        sendFrame(N_INPUTS, N_INPUTS - 1, 0, 0, 0);
        checkOutput("strobe_before_commit", vec_strobe_a, 0);
        tick(1);
        checkOutput("strobe_at_commit", vec_strobe_a, 1);
        checkOutput("vec_data0", vec_data_a[0], 1);
        checkOutput("vec_data63", vec_data_a[63], 64);
        checkOutput("vec_data127", vec_data_a[127], 128);
        tick(LAT - 1);
        checkOutput("res_valid_early", res_valid_a, 0);
        tick(1);
        checkOutput("res_valid_at_lat", res_valid_a, 1);

        $display("[TB] early s_last on beat 63");
        sendFrame(64, 63, 1, 0, 0);
        checkOutput("early_last_err", frame_err_a, 1);
        tick(1);
        checkOutput("early_last_err_pulse", frame_err_a, 0);
        checkOutput("early_last_no_strobe", vec_strobe_a, 0);
        checkOutput("early_last_vec_kept", vec_data_a[0], 1);
        sendFrame(N_INPUTS, N_INPUTS - 1, 1, 0, 0);
        tick(1);
        checkOutput("commit_after_early", vec_strobe_a, 1);

        $display("[TB] missing s_last, drop tail");
        sendFrame(N_INPUTS, -1, 1, 0, 0);
        checkOutput("missing_last_err", frame_err_a, 1);
        sendFrame(10, 9, 1, 0, 0);
        checkOutput("drop_exit_no_err", frame_err_a, 0);
        tick(1);
        checkOutput("drop_no_strobe", vec_strobe_a, 0);
        sendFrame(N_INPUTS, N_INPUTS - 1, 1, 0, 0);
        tick(1);
        checkOutput("commit_after_drop", vec_strobe_a, 1);

        $display("[TB] flush with a result tag in flight");
        sendFrame(N_INPUTS, N_INPUTS - 1, 0, 500, 0);
        tick(1);
        checkOutput("flush_setup_commit", vec_strobe_a, 1);
        applyStimulus(act_t'(7), 1'b0, 0);
        flushCycle();
        for (int i = 0; i < LAT + 1; i++) begin
            checkOutput("flush_res_dropped", res_valid_a, 0);
            tick(1);
        end
        checkOutput("flush_vec_kept", vec_data_a[0], 501);
        sendFrame(N_INPUTS, N_INPUTS - 1, 0, 700, 0);
        tick(1);
        checkOutput("commit_after_flush", vec_strobe_a, 1);
        checkOutput("flush_frame_word0", vec_data_a[0], 701);
        checkOutput("flush_frame_word127", vec_data_a[127], 828);

        $display("[TB] flush at beat 50");
        sendFrame(50, -1, 0, 900, 0);
        flushCycle();
        checkOutput("flush50_no_strobe", vec_strobe_a, 0);
        checkOutput("flush50_vec_kept", vec_data_a[0], 701);
        sendFrame(N_INPUTS, N_INPUTS - 1, 0, 300, 0);
        tick(1);
        checkOutput("flush50_commit", vec_strobe_a, 1);
        checkOutput("flush50_word0", vec_data_a[0], 301);

        $display("[TB] randomized frames");
        for (int f = 0; f < 24; f++) begin
            r = $urandom_range(99);
            if (r < 65) begin
                sendFrame(N_INPUTS, N_INPUTS - 1, 1, 0, 20);
            end else if (r < 78) begin
                len = $urandom_range(N_INPUTS - 2);
                sendFrame(len + 1, len, 1, 0, 20);
            end else if (r < 90) begin
                sendFrame(N_INPUTS, -1, 1, 0, 20);
                len = $urandom_range(12, 1);
                sendFrame(len, len - 1, 1, 0, 20);
            end else begin
                sendFrame($urandom_range(N_INPUTS - 1, 1), -1, 1, 0, 20);
                flushCycle();
            end
            tick($urandom_range(3));
        end
        sendFrame(N_INPUTS, N_INPUTS - 1, 1, 0, 0);
        tick(2);

        $display("[TB] asynchronous reset mid-frame");
        sendFrame(40, -1, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_vec_zero", (vec_data_a == '0), 1);
        checkOutput("async_rst_strobe", vec_strobe_a, 0);
        checkOutput("async_rst_ready", s_ready_a, 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        sendFrame(N_INPUTS, N_INPUTS - 1, 0, 2000, 0);
        tick(1);
        checkOutput("commit_after_reset", vec_strobe_a, 1);
        checkOutput("reset_frame_word5", vec_data_a[5], 2006);

        $display("[TB] long hold between commits");
        doReset();
        use_b = 1'b1;
        sendFrame(N_INPUTS, N_INPUTS - 1, 0, 0, 0);
        tick(1);
        checkOutput("hold_first_commit", vec_strobe_b, 1);
        c1 = cyc;
        sendFrame(N_INPUTS, N_INPUTS - 1, 0, 1000, 0);
        checkOutput("hold_ready_low", s_ready_b, 0);
        checkOutput("hold_frame2_end", cyc - c1, N_INPUTS);
        for (int n = 0; n < 400 && !s_ready_b; n++) tick(1);
        checkOutput("hold_release_cycles", cyc - c1, HOLD_B);
        checkOutput("hold_second_strobe", vec_strobe_b, 1);
        checkOutput("hold_frame2_word0", vec_data_b[0], 1001);
        use_b = 1'b0;
        tick(LAT + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
